// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared constants, FSM states and helpers for the ball collision engine
package ball_pkg;

  localparam int COORD_W   = 10;
  localparam int BALL_SIZE = 4;
  localparam int BRICK_W   = 16;
  localparam int BRICK_H   = 8;
  localparam int SCREEN_W  = 320;
  localparam int SCREEN_H  = 240;
  localparam int PLAT_W    = 40;
  localparam int PLAT_Y    = 224;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SAMPLE, RESOLVE} state_t;

  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    lowest_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) lowest_idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/ball_probe_gen.sv
// rtl/ball_probe_gen.sv - leading-edge probe address and range check for one probe index
module ball_probe_gen #(
  parameter int COORD_W   = 10,
  parameter int BALL_SIZE = 4,
  parameter int SCREEN_W  = 320,
  parameter int SCREEN_H  = 240
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               x_du,
  input  logic               y_du,
  input  logic [1:0]         idx,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  output logic               in_range
);

  localparam logic [COORD_W:0] BS  = (COORD_W+1)'(BALL_SIZE);
  localparam logic [COORD_W:0] ONE = (COORD_W+1)'(1);
  localparam logic [COORD_W:0] SW  = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] SH  = (COORD_W+1)'(SCREEN_H);

  logic [COORD_W:0] xe, ye, lead_x, lead_y, qx, qy;

  // One extra bit: underflow of x-1 / y-1 lands far above the screen size, so a single compare rejects both ends.
  always_comb begin
    xe     = {1'b0, x};
    ye     = {1'b0, y};
    lead_y = y_du ? ye + BS : ye - ONE;
    lead_x = x_du ? xe + BS : xe - ONE;
    qx     = xe;
    qy     = lead_y;
    case (idx)
      2'd0:    begin qx = xe;            qy = lead_y;        end
      2'd1:    begin qx = xe + BS - ONE; qy = lead_y;        end
      2'd2:    begin qx = lead_x;        qy = ye;            end
      default: begin qx = lead_x;        qy = ye + BS - ONE; end
    endcase
    in_range = (qx < SW) && (qy < SH);
    px       = qx[COORD_W-1:0];
    py       = qy[COORD_W-1:0];
  end

endmodule

// File: rtl/ball_collision_engine.sv
// rtl/ball_collision_engine.sv - per-frame ball vs brick/wall/platform collision FSM
module ball_collision_engine #(
  parameter int COORD_W   = ball_pkg::COORD_W,
  parameter int BALL_SIZE = ball_pkg::BALL_SIZE,
  parameter int SCREEN_W  = ball_pkg::SCREEN_W,
  parameter int SCREEN_H  = ball_pkg::SCREEN_H,
  parameter int PLAT_W    = ball_pkg::PLAT_W,
  parameter int PLAT_Y    = ball_pkg::PLAT_Y,
  parameter int MEM_LAT   = 1,
  parameter int HEALTH_W  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                logic_go,
  input  logic [COORD_W-1:0]  ballx,
  input  logic [COORD_W-1:0]  bally,
  input  logic [COORD_W-1:0]  platx,
  output logic                mem_rd,
  output logic [COORD_W-1:0]  memx,
  output logic [COORD_W-1:0]  memy,
  input  logic [HEALTH_W-1:0] health,
  input  logic [COORD_W-1:0]  brickx,
  input  logic [COORD_W-1:0]  bricky,
  output logic                col_valid,
  output logic                col_axis,
  output logic [COORD_W-1:0]  col_x,
  output logic [COORD_W-1:0]  col_y,
  output logic                x_du,
  output logic                y_du,
  output logic                plat_hit,
  output logic                ball_lost,
  output logic                done,
  output logic                busy
);

  import ball_pkg::*;

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [COORD_W:0] BS = (COORD_W+1)'(BALL_SIZE);
  localparam logic [COORD_W:0] SW = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] SH = (COORD_W+1)'(SCREEN_H);
  localparam logic [COORD_W:0] PW = (COORD_W+1)'(PLAT_W);
  localparam logic [COORD_W:0] PY = (COORD_W+1)'(PLAT_Y);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, plat_x_q, plat_x_d;
  logic [3:0]         pend_q, pend_d;
  logic [1:0]         cur_q, cur_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic               xhit_q, xhit_d, yhit_q, yhit_d;
  logic               x_du_q, x_du_d, y_du_q, y_du_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               plat_q, plat_d, lost_q, lost_d;

  logic [COORD_W-1:0] src_x, src_y;
  logic [COORD_W-1:0] prx [4];
  logic [COORD_W-1:0] pry [4];
  logic [3:0]         rng;
  logic [1:0]         iss_idx;
  logic [3:0]         rem;
  logic [COORD_W:0]   x_far, y_far, plat_end;
  logic               y_top, y_floor, y_plat, x_left, x_right;

  // In IDLE the generators look at the live inputs so the first probe can issue the very next cycle.
  assign src_x = (state_q == IDLE) ? ballx : x_q;
  assign src_y = (state_q == IDLE) ? bally : y_q;

  for (genvar g = 0; g < 4; g++) begin : g_probe
    ball_probe_gen #(
      .COORD_W  (COORD_W),
      .BALL_SIZE(BALL_SIZE),
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
    ) u_probe (
      .x       (src_x),
      .y       (src_y),
      .x_du    (x_du_q),
      .y_du    (y_du_q),
      .idx     (2'(g)),
      .px      (prx[g]),
      .py      (pry[g]),
      .in_range(rng[g])
    );
  end

  assign x_far    = {1'b0, x_q} + BS;
  assign y_far    = {1'b0, y_q} + BS;
  assign plat_end = {1'b0, plat_x_q} + PW;
  assign y_top    = (y_q == '0) && !y_du_q;
  assign y_floor  = y_du_q && (y_far >= SH);
  assign y_plat   = y_du_q && (y_far == PY) && (x_far > {1'b0, plat_x_q}) && ({1'b0, x_q} < plat_end);
  assign x_left   = (x_q == '0) && !x_du_q;
  assign x_right  = x_du_q && (x_far >= SW);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    plat_x_d  = plat_x_q;
    pend_d    = pend_q;
    cur_d     = cur_q;
    wcnt_d    = wcnt_q;
    xhit_d    = xhit_q;
    yhit_d    = yhit_q;
    x_du_d    = x_du_q;
    y_du_d    = y_du_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    plat_d    = 1'b0;
    lost_d    = 1'b0;
    mem_rd    = 1'b0;
    memx      = '0;
    memy      = '0;
    col_valid = 1'b0;
    col_axis  = 1'b0;
    col_x     = '0;
    col_y     = '0;
    iss_idx   = lowest_idx(pend_q);
    rem       = pend_q;
    case (state_q)
      IDLE: begin
        if (logic_go) begin
          x_d      = ballx;
          y_d      = bally;
          plat_x_d = platx;
          busy_d   = 1'b1;
          xhit_d   = 1'b0;
          yhit_d   = 1'b0;
          pend_d   = rng;
          state_d  = (|rng) ? ISSUE : RESOLVE;
        end
      end
      ISSUE: begin
        mem_rd  = 1'b1;
        memx    = prx[iss_idx];
        memy    = pry[iss_idx];
        cur_d   = iss_idx;
        pend_d  = pend_q & ~(4'b0001 << iss_idx);
        wcnt_d  = CNT_W'(MEM_LAT - 2);
        state_d = (MEM_LAT == 1) ? SAMPLE : WAIT;
      end
      WAIT: begin
        if (wcnt_q == '0) state_d = SAMPLE;
        else              wcnt_d  = wcnt_q - CNT_W'(1);
      end
      SAMPLE: begin
        if (|health) begin
          col_valid = 1'b1;
          col_axis  = cur_q[1];
          col_x     = brickx;
          col_y     = bricky;
          if (cur_q[1]) xhit_d = 1'b1;
          else          yhit_d = 1'b1;
          // A hit on the first probe of an axis makes its partner redundant.
          if (cur_q == 2'd0) rem[1] = 1'b0;
          if (cur_q == 2'd2) rem[3] = 1'b0;
        end
        pend_d  = rem;
        state_d = (|rem) ? ISSUE : RESOLVE;
      end
      RESOLVE: begin
        if (y_top) begin
          y_du_d = 1'b1;
        end else if (y_floor) begin
          y_du_d = 1'b0;
          lost_d = 1'b1;
        end else if (y_plat) begin
          y_du_d = 1'b0;
          plat_d = 1'b1;
        end else if (yhit_q) begin
          y_du_d = ~y_du_q;
        end
        if (x_left)       x_du_d = 1'b1;
        else if (x_right) x_du_d = 1'b0;
        else if (xhit_q)  x_du_d = ~x_du_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      plat_x_q <= '0;
      pend_q   <= '0;
      cur_q    <= '0;
      wcnt_q   <= '0;
      xhit_q   <= 1'b0;
      yhit_q   <= 1'b0;
      x_du_q   <= 1'b1;
      y_du_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      plat_q   <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      plat_x_q <= plat_x_d;
      pend_q   <= pend_d;
      cur_q    <= cur_d;
      wcnt_q   <= wcnt_d;
      xhit_q   <= xhit_d;
      yhit_q   <= yhit_d;
      x_du_q   <= x_du_d;
      y_du_q   <= y_du_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      plat_q   <= plat_d;
      lost_q   <= lost_d;
    end
  end

  assign x_du      = x_du_q;
  assign y_du      = y_du_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign plat_hit  = plat_q;
  assign ball_lost = lost_q;

endmodule

// File: tb/tb_ball_collision_engine.sv
// tb/tb_ball_collision_engine.sv - directed bench driving MEM_LAT=1 and MEM_LAT=3 instances side by side
module tb_ball_collision_engine;

  localparam int LAT [2] = '{1, 3};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] ballx, bally, platx;
  logic       go [2];
  logic       mem_rd [2];
  logic [9:0] memx [2];
  logic [9:0] memy [2];
  logic [1:0] health [2];
  logic [9:0] brickx [2];
  logic [9:0] bricky [2];
  logic       col_valid [2];
  logic       col_axis [2];
  logic [9:0] col_x [2];
  logic [9:0] col_y [2];
  logic       x_du [2];
  logic       y_du [2];
  logic       plat_hit [2];
  logic       ball_lost [2];
  logic       done [2];
  logic       busy [2];

  always #5 clk = ~clk;

  ball_collision_engine #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .logic_go(go[0]), .ballx(ballx), .bally(bally), .platx(platx),
    .mem_rd(mem_rd[0]), .memx(memx[0]), .memy(memy[0]), .health(health[0]),
    .brickx(brickx[0]), .bricky(bricky[0]), .col_valid(col_valid[0]), .col_axis(col_axis[0]),
    .col_x(col_x[0]), .col_y(col_y[0]), .x_du(x_du[0]), .y_du(y_du[0]),
    .plat_hit(plat_hit[0]), .ball_lost(ball_lost[0]), .done(done[0]), .busy(busy[0])
  );

  ball_collision_engine #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .logic_go(go[1]), .ballx(ballx), .bally(bally), .platx(platx),
    .mem_rd(mem_rd[1]), .memx(memx[1]), .memy(memy[1]), .health(health[1]),
    .brickx(brickx[1]), .bricky(bricky[1]), .col_valid(col_valid[1]), .col_axis(col_axis[1]),
    .col_x(col_x[1]), .col_y(col_y[1]), .x_du(x_du[1]), .y_du(y_du[1]),
    .plat_hit(plat_hit[1]), .ball_lost(ball_lost[1]), .done(done[1]), .busy(busy[1])
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n0 = 0;
  int clr_gen = 0;
  int tgt_x = -1, tgt_y = -1, brk_x = 0, brk_y = 0;

  int ndone [2], dcyc [2], nrd [2], ncol [2], cax [2], cxv [2], cyv [2], np [2], nl [2];
  int rdx [2][8];
  int rdy [2][8];

  int e_p, e_col, e_cax, e_cx, e_cy, e_xdu, e_ydu, e_plat, e_lost;
  int e_rx [4];
  int e_ry [4];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Brick memory: captures requests mid-cycle, answers LAT cycles later just after the clock edge.
  initial begin
    logic       pv [2][4];
    int         pxq [2][4];
    int         pyq [2][4];
    for (int k = 0; k < 2; k++) begin
      health[k] = '0; brickx[k] = '0; bricky[k] = '0;
      for (int s = 0; s < 4; s++) begin pv[k][s] = 1'b0; pxq[k][s] = 0; pyq[k][s] = 0; end
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        for (int s = 3; s > 0; s--) begin
          pv[k][s] = pv[k][s-1]; pxq[k][s] = pxq[k][s-1]; pyq[k][s] = pyq[k][s-1];
        end
        pv[k][0] = mem_rd[k]; pxq[k][0] = int'(memx[k]); pyq[k][0] = int'(memy[k]);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (pv[k][LAT[k]-1] && pxq[k][LAT[k]-1] == tgt_x && pyq[k][LAT[k]-1] == tgt_y) begin
          health[k] = 2'd2; brickx[k] = 10'(brk_x); bricky[k] = 10'(brk_y);
        end else begin
          health[k] = '0; brickx[k] = '0; bricky[k] = '0;
        end
      end
    end
  end

  initial begin
    int seen_gen;
    seen_gen = 0;
    forever begin
      @(negedge clk);
      if (seen_gen != clr_gen) begin
        seen_gen = clr_gen;
        for (int k = 0; k < 2; k++) begin
          ndone[k] = 0; dcyc[k] = 0; nrd[k] = 0; ncol[k] = 0; np[k] = 0; nl[k] = 0;
          cax[k] = 0; cxv[k] = 0; cyv[k] = 0;
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (mem_rd[k]) begin
          if (nrd[k] < 8) begin rdx[k][nrd[k]] = int'(memx[k]); rdy[k][nrd[k]] = int'(memy[k]); end
          nrd[k]++;
        end
        if (col_valid[k]) begin
          ncol[k]++; cax[k] = int'(col_axis[k]); cxv[k] = int'(col_x[k]); cyv[k] = int'(col_y[k]);
        end
        if (done[k]) begin ndone[k]++; dcyc[k] = cyc; end
        if (plat_hit[k]) np[k]++;
        if (ball_lost[k]) nl[k]++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #3 reset = 1'b0;
  endtask

  task automatic no_hit();
    tgt_x = -1; tgt_y = -1; brk_x = 0; brk_y = 0;
  endtask

  task automatic hit_at(input int tx, input int ty, input int bx, input int by);
    tgt_x = tx; tgt_y = ty; brk_x = bx; brk_y = by;
  endtask

  task automatic set_rd(input int p, input int x0, input int y0, input int x1, input int y1,
                        input int x2, input int y2, input int x3, input int y3);
    e_p = p;
    e_rx[0] = x0; e_ry[0] = y0; e_rx[1] = x1; e_ry[1] = y1;
    e_rx[2] = x2; e_ry[2] = y2; e_rx[3] = x3; e_ry[3] = y3;
  endtask

  task automatic set_res(input int col, input int ax, input int cx, input int cy,
                         input int xd, input int yd, input int pl, input int lo);
    e_col = col; e_cax = ax; e_cx = cx; e_cy = cy; e_xdu = xd; e_ydu = yd; e_plat = pl; e_lost = lo;
  endtask

  task automatic start_go(input int bx, input int by, input int px);
    @(posedge clk); #1;
    clr_gen++;
    ballx = 10'(bx); bally = 10'(by); platx = 10'(px);
    go[0] = 1'b1; go[1] = 1'b1;
    n0 = cyc;
    @(posedge clk); #1;
    go[0] = 1'b0; go[1] = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80; i++) begin
      if (ndone[0] > 0 && ndone[1] > 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_case(input string tag);
    string pre;
    for (int k = 0; k < 2; k++) begin
      pre = $sformatf("%s.L%0d", tag, LAT[k]);
      check({pre, ".done_cnt"}, ndone[k], 1);
      check({pre, ".done_cyc"}, dcyc[k] - n0, 2 + e_p * (LAT[k] + 1));
      check({pre, ".reads"}, nrd[k], e_p);
      for (int i = 0; i < e_p && i < nrd[k]; i++)
        check($sformatf("%s.rd%0d_xy", pre, i), rdx[k][i] * 1000 + rdy[k][i], e_rx[i] * 1000 + e_ry[i]);
      check({pre, ".col_cnt"}, ncol[k], e_col);
      if (e_col > 0) check({pre, ".col_ax_xy"}, cax[k] * 1000000 + cxv[k] * 1000 + cyv[k],
                           e_cax * 1000000 + e_cx * 1000 + e_cy);
      check({pre, ".x_du"}, int'(x_du[k]), e_xdu);
      check({pre, ".y_du"}, int'(y_du[k]), e_ydu);
      check({pre, ".plat_hit"}, np[k], e_plat);
      check({pre, ".ball_lost"}, nl[k], e_lost);
      check({pre, ".busy"}, int'(busy[k]), 0);
    end
  endtask

  task automatic run_case(input string tag, input int bx, input int by, input int px);
    start_go(bx, by, px);
    wait_done();
    check_case(tag);
  endtask

  task automatic top_wall();
    no_hit();
    set_rd(2, 104, 0, 104, 3, 0, 0, 0, 0);
    set_res(0, 0, 0, 0, 1, 1, 0, 0);
    run_case("twall", 100, 0, 0);
  endtask

  task automatic check_reset_outs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s.L%0d.x_du", tag, LAT[k]), int'(x_du[k]), 1);
      check($sformatf("%s.L%0d.y_du", tag, LAT[k]), int'(y_du[k]), 0);
      check($sformatf("%s.L%0d.busy", tag, LAT[k]), int'(busy[k]), 0);
      check($sformatf("%s.L%0d.done", tag, LAT[k]), int'(done[k]), 0);
      check($sformatf("%s.L%0d.mem_rd", tag, LAT[k]), int'(mem_rd[k]), 0);
      check($sformatf("%s.L%0d.memxy", tag, LAT[k]), int'(memx[k]) + int'(memy[k]), 0);
      check($sformatf("%s.L%0d.col_valid", tag, LAT[k]), int'(col_valid[k]), 0);
    end
  endtask

  initial begin
    ballx = '0; bally = '0; platx = '0;
    go[0] = 1'b0; go[1] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check_reset_outs("reset");
    @(posedge clk); #3 reset = 1'b0;

    do_reset(); no_hit();
    set_rd(4, 100, 99, 103, 99, 104, 100, 104, 103);
    set_res(0, 0, 0, 0, 1, 0, 0, 0);
    run_case("free", 100, 100, 0);

    do_reset(); hit_at(100, 99, 100, 90);
    set_rd(3, 100, 99, 104, 100, 104, 103, 0, 0);
    set_res(1, 0, 100, 90, 1, 1, 0, 0);
    run_case("p0_hit", 100, 100, 0);

    do_reset(); no_hit();
    set_rd(2, 316, 99, 319, 99, 0, 0, 0, 0);
    set_res(0, 0, 0, 0, 0, 0, 0, 0);
    run_case("rwall", 316, 100, 0);

    do_reset(); hit_at(104, 100, 104, 96);
    set_rd(3, 100, 99, 103, 99, 104, 100, 0, 0);
    set_res(1, 1, 104, 96, 0, 0, 0, 0);
    run_case("p2_hit", 100, 100, 0);

    do_reset(); top_wall();
    set_rd(4, 100, 224, 103, 224, 104, 220, 104, 223);
    set_res(0, 0, 0, 0, 1, 0, 1, 0);
    run_case("plat", 100, 220, 90);

    do_reset(); top_wall();
    set_rd(4, 100, 224, 103, 224, 104, 220, 104, 223);
    set_res(0, 0, 0, 0, 1, 1, 0, 0);
    run_case("plat_miss", 100, 220, 140);

    do_reset(); top_wall();
    set_rd(2, 104, 236, 104, 239, 0, 0, 0, 0);
    set_res(0, 0, 0, 0, 1, 0, 0, 1);
    run_case("floor", 100, 236, 0);

    // Second start pulse while busy must be dropped.
    do_reset(); hit_at(104, 100, 104, 96);
    set_rd(3, 100, 99, 103, 99, 104, 100, 0, 0);
    set_res(1, 1, 104, 96, 0, 0, 0, 0);
    start_go(100, 100, 0);
    while (cyc < n0 + 3) begin @(posedge clk); #1; end
    go[0] = 1'b1; go[1] = 1'b1;
    @(posedge clk); #1;
    go[0] = 1'b0; go[1] = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);
    check_case("rego");

    // Abort mid-evaluation after x_du has been driven to 0.
    do_reset(); no_hit();
    set_rd(2, 316, 99, 319, 99, 0, 0, 0, 0);
    set_res(0, 0, 0, 0, 0, 0, 0, 0);
    run_case("rwall2", 316, 100, 0);
    hit_at(104, 100, 104, 96);
    start_go(100, 100, 0);
    while (cyc < n0 + 4) begin @(posedge clk); #1; end
    check("abort.L1.busy_before", int'(busy[0]), 1);
    #1 reset = 1'b1;
    #1;
    check_reset_outs("abort");
    @(posedge clk); #3 reset = 1'b0;
    repeat (15) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("abort.L%0d.done_cnt", LAT[k]), ndone[k], 0);
      check($sformatf("abort.L%0d.col_cnt", LAT[k]), ncol[k], 0);
    end
    set_rd(3, 100, 99, 103, 99, 104, 100, 0, 0);
    set_res(1, 1, 104, 96, 0, 0, 0, 0);
    run_case("post_abort", 100, 100, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
